// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, SIGN, DONE} div_state_t;

  // One restoring step per dividend bit.
  function automatic int div_iters(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/div_controller.sv
// Divider sequencer: FSM, iteration counter and datapath strobes.
module div_controller
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ge,
  output logic o_cap,
  output logic o_load,
  output logic o_shift,
  output logic o_sub,
  output logic o_fix,
  output logic o_busy,
  output logic o_done
);

  localparam int ITERS = div_iters(WIDTH);
  localparam int CNT_W = $clog2(ITERS) + 1;

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= DIV;
        end
        DIV: begin
          if (r_cnt == CNT_W'(ITERS - 1)) r_state <= SIGN;
          else                            r_cnt   <= r_cnt + CNT_W'(1);
        end
        SIGN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cap   = (r_state == IDLE) && i_start;
  assign o_load  = (r_state == LOAD);
  assign o_shift = (r_state == DIV);
  assign o_sub   = o_shift && i_ge;
  assign o_fix   = (r_state == SIGN);
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/booth_divider.sv
// Signed 2W/W restoring divider with start/done handshake.
// Define DIV_SAT_EN to saturate the quotient on overflow instead of wrapping.
module booth_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               err
);

  localparam int W  = WIDTH;
  localparam int DW = 2 * WIDTH;

  function automatic logic [DW-1:0] mag_dvd(input logic signed [DW-1:0] x);
    return x[DW-1] ? -x : x;
  endfunction

  function automatic logic [W-1:0] mag_dvs(input logic signed [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  function automatic logic [W-1:0] sat_q(input logic neg);
    return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  logic w_cap, w_load, w_shift, w_sub, w_fix, w_ge;

  logic signed [DW-1:0] r_dvd_in;
  logic signed [W-1:0]  r_dvs_in;
  logic [DW-1:0]        r_qm;
  logic [W-1:0]         r_prem;
  logic [W-1:0]         r_dvsm;
  logic                 r_sign_q, r_sign_r, r_dz;

  logic [W:0]           w_trial;
  logic [W-1:0]         w_diff;
  logic signed [DW-1:0] w_q_signed;
  logic signed [W-1:0]  w_r_signed;
  logic                 w_ovf;
  logic [W-1:0]         w_q_out;

  div_controller #(.WIDTH(WIDTH)) u_ctrl (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_ge    (w_ge),
    .o_cap   (w_cap),
    .o_load  (w_load),
    .o_shift (w_shift),
    .o_sub   (w_sub),
    .o_fix   (w_fix),
    .o_busy  (busy),
    .o_done  (done)
  );

  // Restoring step: partial remainder stays below |divisor|, so W bits hold it.
  assign w_trial = {r_prem, r_qm[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvsm});
  assign w_diff  = w_trial[W-1:0] - r_dvsm;

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_dvd_in <= dividend;
      r_dvs_in <= divisor;
    end
    if (w_load) begin
      r_qm     <= mag_dvd(r_dvd_in);
      r_dvsm   <= mag_dvs(r_dvs_in);
      r_prem   <= '0;
      r_sign_q <= r_dvd_in[DW-1] ^ r_dvs_in[W-1];
      r_sign_r <= r_dvd_in[DW-1];
      r_dz     <= (r_dvs_in == '0);
    end else if (w_shift) begin
      r_qm   <= {r_qm[DW-2:0], w_sub};
      r_prem <= w_sub ? w_diff : w_trial[W-1:0];
    end
  end

  // The quotient fits iff its upper W+1 bits are a pure sign extension.
  assign w_q_signed = r_sign_q ? -r_qm : r_qm;
  assign w_r_signed = r_sign_r ? -r_prem : r_prem;
  assign w_ovf      = !((&w_q_signed[DW-1:W-1]) || !(|w_q_signed[DW-1:W-1]));

`ifdef DIV_SAT_EN
  assign w_q_out = w_ovf ? sat_q(r_sign_q) : w_q_signed[W-1:0];
`else
  assign w_q_out = w_q_signed[W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      err       <= 1'b0;
    end else if (w_fix) begin
      if (r_dz) begin
        quotient  <= '1;
        remainder <= r_dvd_in[W-1:0];
        err       <= 1'b1;
      end else begin
        quotient  <= w_q_out;
        remainder <= w_r_signed;
        err       <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=8): vector table, random model, corner sequences.
module tb_booth_divider;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   dividend = '0;
  logic [7:0]    divisor = '0;
  logic          busy, done, err;
  logic [7:0]    quotient, remainder;

  int errors = 0;
  int checks = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        e;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic e);
    int sa, sb, tq, tr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 8'hFF; r = a[7:0]; e = 1'b1;
    end else begin
      tq = sa / sb;
      tr = sa % sb;
      e  = (tq > 127) || (tq < -128);
      q  = tq[7:0];
`ifdef DIV_SAT_EN
      if (e) q = (tq > 0) ? 8'h7F : 8'h80;
`endif
      r  = tr[7:0];
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit timing,
                        output logic [7:0] q, output logic [7:0] r, output logic e);
    int  k_done;
    bit  got;
    got = 0; k_done = 0;
    q = 'x; r = 'x; e = 'x;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(posedge clk); #1;
      if (timing) begin
        chk("busy_timing", busy, (k <= 17) ? 1 : 0);
        chk("done_timing", done, (k == 18) ? 1 : 0);
      end
      if (done) begin
        got = 1; k_done = k;
        q = quotient; r = remainder; e = err;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: no done within 30 cycles for %h/%h", a, b);
    end else begin
      chk("done_latency", k_done, 18);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    logic [7:0] q, r, eq, er;
    logic       e, ee;
    int         ndone;

    vecs[0]  = '{16'd100,  8'd7,   8'h0E, 8'h02, 1'b0};
    vecs[1]  = '{16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0};
    vecs[2]  = '{16'd100,  8'hF9,  8'hF2, 8'h02, 1'b0};
    vecs[3]  = '{16'hFF9C, 8'hF9,  8'h0E, 8'hFE, 1'b0};
`ifdef DIV_SAT_EN
    vecs[4]  = '{16'd1000, 8'd2,   8'h7F, 8'h00, 1'b1};
    vecs[7]  = '{16'h0100, 8'd2,   8'h7F, 8'h00, 1'b1};
    vecs[9]  = '{16'hFEFE, 8'd2,   8'h80, 8'h00, 1'b1};
    vecs[10] = '{16'h8000, 8'hFF,  8'h7F, 8'h00, 1'b1};
`else
    vecs[4]  = '{16'd1000, 8'd2,   8'hF4, 8'h00, 1'b1};
    vecs[7]  = '{16'h0100, 8'd2,   8'h80, 8'h00, 1'b1};
    vecs[9]  = '{16'hFEFE, 8'd2,   8'h7F, 8'h00, 1'b1};
    vecs[10] = '{16'h8000, 8'hFF,  8'h00, 8'h00, 1'b1};
`endif
    vecs[5]  = '{16'h4000, 8'h80,  8'h80, 8'h00, 1'b0};
    vecs[6]  = '{16'h00FE, 8'd2,   8'h7F, 8'h00, 1'b0};
    vecs[8]  = '{16'hFF00, 8'd2,   8'h80, 8'h00, 1'b0};
    vecs[11] = '{16'h1234, 8'h00,  8'hFF, 8'h34, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, (i == 0 || i == 11), q, r, e);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_err", i), e, vecs[i].e);
    end

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom);
      if (i % 5 == 0) a = {{8{a[7]}}, a[7:0]};
      model(a, b, eq, er, ee);
      run_op(a, b, 1'b0, q, r, e);
      chk($sformatf("rnd%0d_quot %h/%h", i, a, b), q, eq);
      chk($sformatf("rnd%0d_rem %h/%h", i, a, b), r, er);
      chk($sformatf("rnd%0d_err %h/%h", i, a, b), e, ee);
    end

    // Multiplier round trip: (A*B)/B == A
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ma, mb;
      int         p;
      ma = 8'($urandom);
      mb = 8'($urandom_range(1, 255));
      p  = int'($signed(ma)) * int'($signed(mb));
      run_op(p[15:0], mb, 1'b0, q, r, e);
      chk($sformatf("mul%0d_quot", i), q, ma);
      chk($sformatf("mul%0d_rem", i), r, 0);
      chk($sformatf("mul%0d_err", i), e, 0);
    end

    // Reset during iteration 5 aborts immediately
    dividend = 16'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    run_op(16'd50, 8'd5, 1'b1, q, r, e);
    chk("post_rst_quot", q, 10);
    chk("post_rst_rem", r, 0);
    chk("post_rst_err", e, 0);

    // Start held high for 40 cycles: exactly two operations
    ndone = 0;
    dividend = 16'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_done_k%0d", k), done, (k == 18 || k == 38) ? 1 : 0);
      if (done) ndone++;
      if (k >= 18 && k <= 38) begin
        chk($sformatf("hold_quot_k%0d", k), quotient, 66);
        chk($sformatf("hold_rem_k%0d", k), remainder, 2);
      end
      if (k == 39) start = 1'b0;
    end
    chk("hold_pulse_count", ndone, 2);
    chk("hold_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
